// File: rtl/i2c_write_scheduler.sv
// Init sequencer and round-robin write arbiter in front of the I2C frame
// output block; one address/data pair per start/complete transaction.
module i2c_write_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_addr,
    input  logic [7:0] i_req0_data,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_addr,
    input  logic [7:0] i_req1_data,
    output logic       o_req1_ready,
    output logic [7:0] o_register_addr,
    output logic [7:0] o_data,
    output logic       o_start,
    input  logic       i_complete,
    output logic       o_init_done,
    output logic       o_busy,
    output logic       o_timeout_err
);

    typedef enum logic [2:0] {
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_ARB,
        S_ISSUE,
        S_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cmpl_q;

    logic [7:0]  rom_addr, rom_data;
    logic [16:0] cnt_inc;
    logic        evt, tmo, gnt0, gnt1;

    // PCA9685 bring-up: sleep, 50 Hz prescale, wake with auto-increment, totem-pole
    always_comb begin
        rom_addr = 8'h00;
        rom_data = 8'h10;
        unique case (step_q)
            2'd0: begin rom_addr = 8'h00; rom_data = 8'h10; end
            2'd1: begin rom_addr = 8'hFE; rom_data = 8'h79; end
            2'd2: begin rom_addr = 8'h00; rom_data = 8'h20; end
            2'd3: begin rom_addr = 8'h01; rom_data = 8'h04; end
            default: ;
        endcase
    end

    assign evt     = i_complete & ~cmpl_q;
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    assign tmo     = cnt_inc >= 17'(TIMEOUT_CYCLES);

    // On a tie, the requester that did not win last time goes next
    assign gnt0 = i_req0_valid & (~i_req1_valid | last_q);
    assign gnt1 = i_req1_valid & (~i_req0_valid | ~last_q);

    assign o_req0_ready    = (state_q == S_ARB) & gnt0;
    assign o_req1_ready    = (state_q == S_ARB) & gnt1;
    assign o_busy          = (state_q != S_ARB);
    assign o_start         = start_q;
    assign o_register_addr = addr_q;
    assign o_data          = data_q;
    assign o_init_done     = done_q;
    assign o_timeout_err   = err_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        start_d = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            S_INIT_ISSUE: begin
                start_d = 1'b1;
                addr_d  = rom_addr;
                data_d  = rom_data;
                cnt_d   = '0;
                state_d = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                cnt_d = cnt_inc[15:0];
                if (evt) begin
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = S_ARB;
                    end else begin
                        state_d = S_INIT_ISSUE;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    step_d  = 2'd0;
                    state_d = S_INIT_ISSUE;
                end
            end
            S_ARB: begin
                if (gnt0 | gnt1) begin
                    addr_d  = gnt1 ? i_req1_addr : i_req0_addr;
                    data_d  = gnt1 ? i_req1_data : i_req0_data;
                    last_d  = gnt1;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc[15:0];
                if (evt) begin
                    state_d = S_ARB;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_ARB;
                end
            end
            default: state_d = S_INIT_ISSUE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_INIT_ISSUE;
            step_q  <= 2'd0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cmpl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cmpl_q  <= i_complete;
        end
    end

endmodule
